stoch_mult_engine: RTL and testbench

Parametrised stochastic-computing multiply engine, the next generation of our fixed 4-bit/8-cycle stochastic multiplier. It converts two PW-bit binary probabilities to bitstreams with two independent 31-bit LFSRs, multiplies them in unipolar (AND) or bipolar (XNOR) mode, and counts the product stream over 2^LOG_LEN cycles. It sits between the tile input pins and the binary readout. It adds a start/busy/done handshake, a per-operation mode select, a count that cannot overflow, and a signed bipolar readout.

---
 rtl/stoch_mult_engine.sv | 137 +++++++++++++
 tb/tb_stoch_mult_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stoch_mult_engine.sv
// stoch_mult_engine
// Stochastic-computing multiplier. Two PW-bit probabilities are turned into
// bitstreams by comparing them against two independent 31-bit LFSRs. The
// streams are combined with AND (unipolar) or XNOR (bipolar), and the ones in
// the product stream are counted over 2^LOG_LEN cycles. A start/busy/done
// handshake controls each operation, and the result is also given as a signed
// bipolar value.
module stoch_mult_engine #(
  parameter int          PW      = 4,
  parameter int          LOG_LEN = 3,
  parameter logic [30:0] SEED_A  = 31'h0000_0001,
  parameter logic [30:0] SEED_B  = 31'h0000_0002
) (
  input  logic                      clk,
  input  logic                      rst_n,     // active-high despite the name
  input  logic                      start,
  input  logic                      mode,
  input  logic [PW-1:0]             prob_a,
  input  logic [PW-1:0]             prob_b,
  output logic                      busy,
  output logic                      done,
  output logic [LOG_LEN:0]          result,
  output logic signed [LOG_LEN+1:0] result_bp
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Stream length L and -L in the bipolar readout width.
  localparam logic [LOG_LEN+1:0] L_BP  = {2'b01, {LOG_LEN{1'b0}}};
  localparam logic [LOG_LEN+1:0] NEG_L = {2'b11, {LOG_LEN{1'b0}}};

  state_t             state_reg;
  logic [30:0]        lfsr_a_reg;
  logic [30:0]        lfsr_b_reg;
  logic [30:0]        lfsr_a_next;
  logic [30:0]        lfsr_b_next;
  logic [LOG_LEN-1:0] cnt_reg;
  logic [LOG_LEN:0]   acc_reg;
  logic [LOG_LEN:0]   acc_next;
  logic [PW-1:0]      pa_reg;
  logic [PW-1:0]      pb_reg;
  logic               mode_reg;
  logic [PW-1:0]      rn_a;
  logic [PW-1:0]      rn_b;
  logic               sn_a;
  logic               sn_b;
  logic               p_bit;
  logic               busy_reg;
  logic               done_reg;
  logic [LOG_LEN:0]   result_reg;
  logic [LOG_LEN+1:0] result_bp_reg;
  logic [LOG_LEN+1:0] bp_next;

  // Random numbers are the top PW bits of each LFSR.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_rn
      assign rn_a[gi] = lfsr_a_reg[31-PW+gi];
      assign rn_b[gi] = lfsr_b_reg[31-PW+gi];
    end
  endgenerate

  // Stream bits, product bit, and the next accumulator and readout values.
  // The accumulator is one bit wider than the counter, so it can hold full
  // scale L without wrapping.
  assign sn_a     = (rn_a < pa_reg);
  assign sn_b     = (rn_b < pb_reg);
  assign p_bit    = mode_reg ? ~(sn_a ^ sn_b) : (sn_a & sn_b);
  assign acc_next = acc_reg + {{LOG_LEN{1'b0}}, p_bit};
  assign bp_next  = {acc_next, 1'b0} - L_BP;

  // Fibonacci shift-left LFSRs: x^31+x^28+1 for A and x^31+x^13+1 for B.
  assign lfsr_a_next = {lfsr_a_reg[29:0], lfsr_a_reg[30] ^ lfsr_a_reg[27]};
  assign lfsr_b_next = {lfsr_b_reg[29:0], lfsr_b_reg[30] ^ lfsr_b_reg[12]};

  // The LFSRs advance only while streaming. Only reset restores the seeds,
  // so each operation continues from where the previous one stopped.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      lfsr_a_reg <= SEED_A;
      lfsr_b_reg <= SEED_B;
    end else if (state_reg == RUN) begin
      lfsr_a_reg <= lfsr_a_next;
      lfsr_b_reg <= lfsr_b_next;
    end
  end

  // Control FSM. It captures the operands, counts the stream and registers
  // the result. done is a one-cycle pulse on the edge that leaves RUN.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      pa_reg        <= '0;
      pb_reg        <= '0;
      mode_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      result_reg    <= '0;
      result_bp_reg <= NEG_L;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            pa_reg    <= prob_a;
            pb_reg    <= prob_b;
            mode_reg  <= mode;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == '1) begin
            result_reg    <= acc_next;
            result_bp_reg <= bp_next;
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign result    = result_reg;
  assign result_bp = result_bp_reg;

endmodule

// File: tb/tb_stoch_mult_engine.sv
// Testbench for stoch_mult_engine. It runs two instances: the default
// configuration (PW=4, LOG_LEN=3) and a wide one (PW=8, LOG_LEN=10). A
// sequence model of the LFSR polynomials predicts every result.
module tb_stoch_mult_engine;

  logic clk = 1'b0;
  logic rst_n;

  logic        start0, mode0, busy0, done0;
  logic [3:0]  pa0, pb0;
  logic [3:0]  res0;
  logic signed [4:0] bp0;

  logic        start1, mode1, busy1, done1;
  logic [7:0]  pa1, pb1;
  logic [10:0] res1;
  logic signed [11:0] bp1;

  int checks = 0;
  int errors = 0;
  int op_no  = 0;

  // Model LFSR state for each instance.
  int unsigned ma [2];
  int unsigned mb [2];

  always #5 clk = ~clk;

  stoch_mult_engine u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0),
    .prob_a(pa0), .prob_b(pb0), .busy(busy0), .done(done0),
    .result(res0), .result_bp(bp0)
  );

  stoch_mult_engine #(.PW(8), .LOG_LEN(10)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1),
    .prob_a(pa1), .prob_b(pb1), .busy(busy1), .done(done1),
    .result(res1), .result_bp(bp1)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] get_busy(input int w);
    return w != 0 ? 32'(busy1) : 32'(busy0);
  endfunction
  function automatic logic signed [31:0] get_done(input int w);
    return w != 0 ? 32'(done1) : 32'(done0);
  endfunction
  function automatic logic signed [31:0] get_res(input int w);
    return w != 0 ? 32'(res1) : 32'(res0);
  endfunction
  function automatic logic signed [31:0] get_bp(input int w);
    return w != 0 ? 32'(bp1) : 32'(bp0);
  endfunction

  task automatic set_start(input int w, input bit v);
    if (w != 0) start1 = v; else start0 = v;
  endtask

  task automatic drive(input int w, input int pa, input int pb, input bit md);
    if (w != 0) begin
      start1 = 1'b1; pa1 = 8'(pa); pb1 = 8'(pb); mode1 = md;
    end else begin
      start0 = 1'b1; pa0 = 4'(pa); pb0 = 4'(pb); mode0 = md;
    end
  endtask

  function automatic int unsigned lfsr_step(input int unsigned q, input int tap);
    return ((q << 1) | (((q >> 30) ^ (q >> tap)) & 1)) & 32'h7fff_ffff;
  endfunction

  // Reference: count the ones in the product stream over L cycles.
  task automatic model_op(input int w, input int pa, input int pb,
                          input bit md, output int cnt);
    int pw = (w != 0) ? 8 : 4;
    int len = (w != 0) ? 1024 : 8;
    int ra, rb;
    bit sa, sb;
    cnt = 0;
    for (int k = 0; k < len; k++) begin
      ra = int'(ma[w] >> (31 - pw));
      rb = int'(mb[w] >> (31 - pw));
      sa = (ra < pa);
      sb = (rb < pb);
      if (md ? (sa == sb) : (sa && sb)) cnt++;
      ma[w] = lfsr_step(ma[w], 27);
      mb[w] = lfsr_step(mb[w], 12);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      ma[w] = 1;
      mb[w] = 2;
    end
  endtask

  // One full operation, starting from an IDLE/done cycle at posedge+1.
  // inject=1 pulses start and changes the operands during RUN.
  // hold=1 leaves start high.
  task automatic run_op(input int w, input int pa, input int pb, input bit md,
                        input bit inject, input bit hold);
    int len = (w != 0) ? 1024 : 8;
    int cnt;
    drive(w, pa, pb, md);
    model_op(w, pa, pb, md, cnt);
    @(posedge clk); #1;
    if (!hold) set_start(w, 1'b0);
    for (int k = 0; k < len; k++) begin
      chk("busy_in_run", get_busy(w), 1);
      chk("done_in_run", get_done(w), 0);
      if (inject && k == 2) begin
        if (w != 0) begin pa1 = ~pa1; mode1 = ~mode1; end
        else begin pa0 = ~pa0; mode0 = ~mode0; end
        set_start(w, 1'b1);
      end
      if (inject && k == 3) set_start(w, 1'b0);
      @(posedge clk); #1;
    end
    chk("done_pulse", get_done(w), 1);
    chk("busy_done", get_busy(w), 0);
    chk("result", get_res(w), cnt);
    chk("result_bp", get_bp(w), 2 * cnt - len);
    op_no++;
    $display("op %0d dut%0d mode=%0d pa=%0d pb=%0d result=%0d result_bp=%0d expected=%0d",
             op_no, w, md, pa, pb, get_res(w), get_bp(w), cnt);
  endtask

  initial begin
    rst_n = 1'b1;
    start0 = 0; mode0 = 0; pa0 = 0; pb0 = 0;
    start1 = 0; mode1 = 0; pa1 = 0; pb1 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_busy0", get_busy(0), 0);
    chk("rst_done0", get_done(0), 0);
    chk("rst_res0", get_res(0), 0);
    chk("rst_bp0", get_bp(0), -8);
    chk("rst_bp1", get_bp(1), -1024);
    #3 rst_n = 1'b0;
    @(posedge clk); #1;

    // Seeds give rn=0 for the first 8 cycles, so 1*1 streams are all ones.
    run_op(0, 1, 1, 1'b0, 1'b0, 1'b0);
    chk("t1_result_const", get_res(0), 8);
    chk("t1_bp_const", get_bp(0), 8);
    // Bipolar 0,0: XNOR of two zero streams is full scale.
    run_op(0, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("t2_result_full", get_res(0), 8);
    chk("t2_bp_full", get_bp(0), 8);
    run_op(0, 0, 5, 1'b0, 1'b0, 1'b0);
    chk("t2_result_zero", get_res(0), 0);
    chk("t2_bp_zero", get_bp(0), -8);

    // A restart attempt and operand change during RUN are ignored.
    run_op(0, 9, 12, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("no_second_done", get_done(0), 0);
    chk("no_restart_busy", get_busy(0), 0);

    // Reset mid-RUN aborts with no done pulse. The seeds are restored.
    drive(0, 1, 1, 1'b0);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    #1;
    chk("abort_busy", get_busy(0), 0);
    chk("abort_done", get_done(0), 0);
    chk("abort_result", get_res(0), 0);
    chk("abort_bp", get_bp(0), -8);
    model_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", get_done(0), 0);
    end
    run_op(0, 1, 1, 1'b0, 1'b0, 1'b0);
    chk("t5_result_repro", get_res(0), 8);

    // start held high: back-to-back operations, each starting in the done cycle.
    for (int i = 0; i < 3; i++) run_op(0, 11, 6, 1'b1, 1'b0, 1'b1);
    set_start(0, 1'b0);
    @(posedge clk); #1;
    chk("hold_idle_busy", get_busy(0), 0);
    chk("hold_idle_done", get_done(0), 0);

    // Random operations on the default instance. Idle gaps are inserted.
    for (int i = 0; i < 200; i++) begin
      run_op(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("gap_done0", get_done(0), 0);
      end
    end

    // Random operations on the wide instance.
    for (int i = 0; i < 40; i++) begin
      run_op(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
